// File: rtl/video_pattern_gen.sv
// Test-pattern source feeding the HDMI transmitter: colour bars, checkerboard,
// gradient or bouncing box, with the pattern and animation state advanced once per frame.
module video_pattern_gen #(
  parameter logic [9:0]  BOX_SIZE = 10'd32,
  parameter logic [9:0]  BOX_DX   = 10'd2,
  parameter logic [9:0]  BOX_DY   = 10'd1,
  parameter logic [23:0] BG_COLOR = 24'h000040
) (
  input  logic        clk_pix,
  input  logic        rst_in,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  input  logic [9:0]  screen_start_x,
  input  logic [9:0]  screen_start_y,
  input  logic [9:0]  screen_width,
  input  logic [9:0]  screen_height,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] rgb,
  output logic        frame_tick
);

  logic [23:0] rgb_q, rgb_d;
  logic        tick_q, tick_d;
  logic [1:0]  pat_q, pat_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic [9:0]  bx_q, bx_d, by_q, by_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [9:0]  bar_cnt_q, bar_cnt_d;
  logic [9:0]  bar_w_q, bar_w_d;

  logic        fs_s, active_s, in_box_s;
  logic [9:0]  x_s, y_s, bar_w_raw_s;
  logic [23:0] colour_s;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = 24'hFFFFFF;
      3'd1:    bar_colour = 24'hFFFF00;
      3'd2:    bar_colour = 24'h00FFFF;
      3'd3:    bar_colour = 24'h00FF00;
      3'd4:    bar_colour = 24'hFF00FF;
      3'd5:    bar_colour = 24'hFF0000;
      3'd6:    bar_colour = 24'h0000FF;
      default: bar_colour = 24'h000000;
    endcase
  endfunction

  assign fs_s        = (cx == 10'd0) && (cy == 10'd0);
  assign active_s    = (cx >= screen_start_x) && (cy >= screen_start_y);
  assign x_s         = cx - screen_start_x;
  assign y_s         = cy - screen_start_y;
  assign bar_w_raw_s = {3'b000, screen_width[9:3]};
  assign in_box_s    = (x_s >= bx_q) && (x_s < bx_q + BOX_SIZE) &&
                       (y_s >= by_q) && (y_s < by_q + BOX_SIZE);

  // Frame-synchronous state: pattern latch, bar width, frame counter, box step.
  always_comb begin
    pat_d       = pat_q;
    bar_w_d     = bar_w_q;
    frame_cnt_d = frame_cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    if (fs_s) begin
      pat_d       = pattern_sel;
      bar_w_d     = (bar_w_raw_s == 10'd0) ? 10'd1 : bar_w_raw_s;
      frame_cnt_d = frame_cnt_q + 8'd1;
      if (dir_x_q) begin
        if (bx_q >= screen_width - BOX_SIZE - BOX_DX) begin
          bx_d    = screen_width - BOX_SIZE;
          dir_x_d = 1'b0;
        end else begin
          bx_d = bx_q + BOX_DX;
        end
      end else begin
        if (bx_q <= BOX_DX) begin
          bx_d    = 10'd0;
          dir_x_d = 1'b1;
        end else begin
          bx_d = bx_q - BOX_DX;
        end
      end
      if (dir_y_q) begin
        if (by_q >= screen_height - BOX_SIZE - BOX_DY) begin
          by_d    = screen_height - BOX_SIZE;
          dir_y_d = 1'b0;
        end else begin
          by_d = by_q + BOX_DY;
        end
      end else begin
        if (by_q <= BOX_DY) begin
          by_d    = 10'd0;
          dir_y_d = 1'b1;
        end else begin
          by_d = by_q - BOX_DY;
        end
      end
    end
  end

  // Bar walker: restarts on every blanking cycle so each line begins at bar 0.
  always_comb begin
    bar_idx_d = 3'd0;
    bar_cnt_d = 10'd0;
    if (active_s) begin
      if (bar_cnt_q == bar_w_q - 10'd1) begin
        bar_cnt_d = 10'd0;
        bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + 10'd1;
        bar_idx_d = bar_idx_q;
      end
    end else begin
      bar_idx_d = 3'd0;
      bar_cnt_d = 10'd0;
    end
  end

  // Pixel colour from the pattern latched at the last frame start.
  always_comb begin
    colour_s = 24'h000000;
    case (pat_q)
      2'd0:    colour_s = bar_colour(bar_idx_q);
      2'd1:    colour_s = (x_s[5] == y_s[5]) ? 24'hFFFFFF : 24'h000000;
      2'd2:    colour_s = {x_s[7:0], y_s[7:0], frame_cnt_q};
      default: colour_s = in_box_s ? 24'hFFFFFF : BG_COLOR;
    endcase
    rgb_d  = active_s ? colour_s : 24'h000000;
    tick_d = fs_s;
  end

  // State and output registers.
  always_ff @(posedge clk_pix or posedge rst_in) begin
    if (rst_in) begin
      rgb_q       <= 24'h000000;
      tick_q      <= 1'b0;
      pat_q       <= 2'd0;
      frame_cnt_q <= 8'd0;
      bx_q        <= 10'd0;
      by_q        <= 10'd0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      bar_idx_q   <= 3'd0;
      bar_cnt_q   <= 10'd0;
      bar_w_q     <= 10'd1;
    end else begin
      rgb_q       <= rgb_d;
      tick_q      <= tick_d;
      pat_q       <= pat_d;
      frame_cnt_q <= frame_cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      bar_idx_q   <= bar_idx_d;
      bar_cnt_q   <= bar_cnt_d;
      bar_w_q     <= bar_w_d;
    end
  end

  assign rgb        = rgb_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen: the bench plays the transmitter and
// drives cx/cy directly, issuing frame starts as single (0,0) cycles.
module tb_video_pattern_gen;

  logic        clk_pix;
  logic        rst_in;
  logic [9:0]  cx, cy;
  logic [9:0]  screen_start_x, screen_start_y, screen_width, screen_height;
  logic [1:0]  pattern_sel;
  logic [23:0] rgb;
  logic        frame_tick;

  int checks;
  int failures;

  video_pattern_gen dut (
    .clk_pix        (clk_pix),
    .rst_in         (rst_in),
    .cx             (cx),
    .cy             (cy),
    .screen_start_x (screen_start_x),
    .screen_start_y (screen_start_y),
    .screen_width   (screen_width),
    .screen_height  (screen_height),
    .pattern_sel    (pattern_sel),
    .rgb            (rgb),
    .frame_tick     (frame_tick)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one coordinate, clock it in, and settle 1 time unit after the edge.
  task automatic step(input logic [9:0] x, input logic [9:0] y);
    cx = x;
    cy = y;
    @(posedge clk_pix);
    #1;
  endtask

  task automatic frame_starts(input int n);
    for (int k = 0; k < n; k++) step(10'd0, 10'd0);
    step(10'd1, 10'd0);
  endtask

  // Local coordinate helper (default geometry: start 160,45).
  task automatic loc(input int x, input int y);
    step(10'(x + 160), 10'(y + 45));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    screen_start_x = 10'd160;
    screen_start_y = 10'd45;
    screen_width   = 10'd640;
    screen_height  = 10'd480;
    pattern_sel    = 2'd0;
    rst_in         = 1'b1;
    cx = 10'd0;
    cy = 10'd0;

    // Reset holds outputs low even on an FS and an active pixel.
    step(10'd0, 10'd0);
    chk("rst_tick", {23'd0, frame_tick}, 24'd0);
    step(10'd160, 10'd45);
    chk("rst_rgb", rgb, 24'h000000);
    rst_in = 1'b0;

    // Frame start pulse, one cycle wide.
    step(10'd0, 10'd0);
    chk("fs_tick_hi", {23'd0, frame_tick}, 24'd1);
    step(10'd1, 10'd0);
    chk("fs_tick_lo", {23'd0, frame_tick}, 24'd0);

    // Colour bars on row 45; bar width 80.
    for (int i = 0; i < 800; i++) begin
      step(10'(i), 10'd45);
      if (i == 100) chk("bar_blank", rgb, 24'h000000);
      if (i == 160) chk("bar_160", rgb, 24'hFFFFFF);
      if (i == 239) chk("bar_239", rgb, 24'hFFFFFF);
      if (i == 240) chk("bar_240", rgb, 24'hFFFF00);
      if (i == 719) chk("bar_719", rgb, 24'h0000FF);
      if (i == 720) chk("bar_720", rgb, 24'h000000);
    end

    // Mid-frame select change is ignored until the next FS.
    pattern_sel = 2'd1;
    for (int i = 0; i < 300; i++) begin
      step(10'(i), 10'd100);
      if (i == 240) chk("latch_bars", rgb, 24'hFFFF00);
    end
    frame_starts(1);
    loc(0, 0);   chk("chk_0_0", rgb, 24'hFFFFFF);
    loc(31, 0);  chk("chk_31_0", rgb, 24'hFFFFFF);
    loc(32, 0);  chk("chk_32_0", rgb, 24'h000000);
    loc(32, 32); chk("chk_32_32", rgb, 24'hFFFFFF);

    // Gradient in frame 5 after reset, then 256 frames later.
    rst_in = 1'b1;
    step(10'd5, 10'd5);
    rst_in = 1'b0;
    pattern_sel = 2'd2;
    frame_starts(5);
    loc(8'h12, 8'h34);
    chk("grad_f5", rgb, 24'h123405);
    frame_starts(256);
    loc(8'h12, 8'h34);
    chk("grad_wrap", rgb, 24'h123405);

    // Bouncing box from reset.
    rst_in = 1'b1;
    step(10'd5, 10'd5);
    rst_in = 1'b0;
    pattern_sel = 2'd3;
    frame_starts(1);
    loc(2, 1);    chk("box1_in", rgb, 24'hFFFFFF);
    loc(1, 1);    chk("box1_left", rgb, 24'h000040);
    loc(33, 32);  chk("box1_far", rgb, 24'hFFFFFF);
    loc(34, 1);   chk("box1_right", rgb, 24'h000040);
    frame_starts(303);
    loc(608, 304); chk("box304_in", rgb, 24'hFFFFFF);
    loc(607, 304); chk("box304_out", rgb, 24'h000040);
    frame_starts(1);
    loc(606, 305); chk("box305_in", rgb, 24'hFFFFFF);
    loc(605, 305); chk("box305_out", rgb, 24'h000040);
    frame_starts(143);
    loc(320, 448); chk("box448_in", rgb, 24'hFFFFFF);
    loc(320, 447); chk("box448_out", rgb, 24'h000040);
    frame_starts(1);
    loc(318, 447); chk("box449_in", rgb, 24'hFFFFFF);
    loc(318, 446); chk("box449_out", rgb, 24'h000040);

    // Asynchronous reset mid-frame at (400,200).
    step(10'd400, 10'd200);
    chk("pre_rst_bg", rgb, 24'h000040);
    rst_in = 1'b1;
    #2;
    chk("async_rst", rgb, 24'h000000);
    step(10'd400, 10'd200);
    step(10'd400, 10'd200);
    step(10'd400, 10'd200);
    chk("rst_hold", rgb, 24'h000000);
    rst_in = 1'b0;
    step(10'd400, 10'd200); chk("post_rst_bar0", rgb, 24'hFFFFFF);
    step(10'd401, 10'd200); chk("post_rst_bar1", rgb, 24'hFFFF00);
    frame_starts(1);
    loc(2, 1); chk("post_rst_box_in", rgb, 24'hFFFFFF);
    loc(1, 1); chk("post_rst_box_out", rgb, 24'h000040);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
